fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch stage: owns the fetch PC, issues requests to a variable-latency instruction memory with a req/ack handshake, and presents pc_F, pc4_F, IR_F and valid_F to the D stage.
- Honours the hazard stall (stop) and applies D-stage branch/jump redirects with MIPS single-delay-slot semantics.
- Discards wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_3000, address of the first fetch after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- stop  in  1  D stage stalled; F outputs must hold.
- redirect  in  1  D-stage control transfer taken this cycle; only asserted with stop=0.
- redirect_pc  in  32  target of the control transfer.
- im_req  out  1  fetch request to instruction memory.
- im_addr  out  32  word-aligned fetch address.
- im_ack  in  1  im_rdata valid; completes the current request.
- im_rdata  in  32  fetched instruction word.
- pc_F  out  32  PC of the instruction in F.
- pc4_F  out  32  pc_F + 4.
- IR_F  out  32  instruction in F.
- valid_F  out  1  IR_F holds a real instruction; 0 means bubble.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - state=FETCH, fetch_pc=RESET_PC.
  - pc_F=RESET_PC, IR_F=0, valid_F=0.
  - pend_valid=0, kill=0, buffer empty.
  - im_req=0 in any cycle where reset=1.
- Reset mid-request abandons the request. An im_ack arriving while im_req=0 is ignored.
- Internal registers: fetch_pc[31:0], pend_pc[31:0]/pend_valid, kill, buf_ir/buf_pc (one-entry skid buffer).
- pc4_F = pc_F + 4, combinational, mod 2^32. Wrap at 32'hFFFF_FFFC gives 0, no error.
- Handshake:
  - im_req=1 only in state FETCH.
  - im_addr = fetch_pc, held stable until im_ack.
  - A request is never withdrawn before its ack. Ack may arrive in the same cycle as req (0-wait).
- "Fetch completes" means im_req and im_ack both high.
- State FETCH:
  - Completion with kill=1: drop data, clear kill, fetch_pc <= pend_pc, clear pend_valid.
  - Completion with kill=0 and stop=0: IR_F <= im_rdata, pc_F <= fetch_pc, valid_F <= 1.
  - Completion with kill=0 and stop=1: buf <= {im_rdata, fetch_pc}, go to HOLD. F outputs unchanged.
  - After a non-killed completion, fetch_pc <= pend_valid ? pend_pc : fetch_pc + 4, and pend_valid clears.
  - No completion and stop=0: valid_F <= 0 (bubble; D consumed the previous instruction).
  - stop=1: F outputs hold, always.
- State HOLD:
  - im_req=0.
  - When stop=0: F outputs <= buf with valid_F=1, go to FETCH.
- Redirect (sampled when redirect=1; stop=0 guaranteed):
  - Case A, delay slot already fetched (valid_F=1 with no completion this cycle, or state=HOLD): any in-flight fetch is wrong-path.
    - If a request is in flight and not completing this cycle: kill <= 1, pend <= redirect_pc.
    - If a fetch completes this cycle it is discarded, and fetch_pc <= redirect_pc.
    - If state=HOLD: fetch_pc <= redirect_pc directly.
  - Case B, delay slot is the in-flight fetch (valid_F=0, state FETCH):
    - pend <= redirect_pc, pend_valid <= 1.
    - If it completes this same cycle, it is loaded normally and fetch_pc <= redirect_pc.
- redirect while pend_valid=1 or kill=1 is illegal (simulation assertion). Hardware keeps the older pending target.
- Killed fetches never reach IR_F or the buffer.

Test Plan:
- Reset, 0-wait memory (ack same cycle), stop=0 -> im_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; valid_F=1 from the first fetch onward; pc4_F = pc_F+4.
- 2-cycle ack latency -> valid_F pattern 0,1,0,1; pc_F 0x3000, then 0x3004; im_addr stable while waiting.
- stop=1 for 3 cycles with an ack inside the stall -> outputs frozen, buffer holds the next instruction (0x3008), im_req=0 in HOLD; after stop=0, 0x3008 appears and the next im_addr is 0x300C.
- Branch at 0x3004 in D redirects to 0x3100, delay slot 0x3008 already in F, fetch 0x300C in flight -> 0x300C ack discarded; next im_addr 0x3100; F sequence 0x3008, bubble(s), 0x3100.
- Redirect while the delay slot 0x3008 fetch is in flight (valid_F=0) -> 0x3008 delivered with valid_F=1, next im_addr 0x3100, no fetch of 0x300C.
- reset asserted during an outstanding request, late ack arrives -> ack ignored, first post-reset im_addr 0x3000, IR_F=0, valid_F=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the fetch PC and issues req/ack fetches to a variable-latency
// instruction memory. It presents pc_F/pc4_F/IR_F/valid_F to the D stage,
// honours the D-stage stall (stop) and applies D-stage redirects with a
// single branch delay slot. Wrong-path fetches are discarded.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   stop             D stalled: F outputs hold
//   redirect         D-stage control transfer taken (only with stop=0)
//   redirect_pc      control transfer target
//   im_req, im_addr  fetch request and word address (held until im_ack)
//   im_ack, im_rdata fetch completion and instruction word
//   pc_F, pc4_F      PC of the F instruction and PC+4
//   IR_F, valid_F    F instruction and its valid flag (0 = bubble)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] pc4_F,
  output logic [31:0] IR_F,
  output logic        valid_F
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_d;
  logic [31:0] fetch_pc, fetch_pc_d;
  logic [31:0] pend_pc, pend_pc_d;
  logic        pend_valid, pend_valid_d;
  logic        kill, kill_d;
  logic [31:0] buf_ir, buf_ir_d;
  logic [31:0] buf_pc, buf_pc_d;
  logic [31:0] pc_F_d, IR_F_d;
  logic        valid_F_d;

  logic complete;
  logic redir_ok;
  logic slot_in_f;

  assign im_req   = (state == FETCH) && !reset;
  assign im_addr  = fetch_pc;
  assign pc4_F    = pc_F + 32'd4;
  assign complete = im_req && im_ack;
  // A second redirect while one is still pending is ignored so the older
  // target wins.
  assign redir_ok = redirect && !pend_valid && !kill;
  // The delay slot has already been fetched: it sits in F or in the buffer,
  // so whatever the memory is working on is wrong-path.
  assign slot_in_f = (state == HOLD) || valid_F;

  always_comb begin
    state_d      = state;
    fetch_pc_d   = fetch_pc;
    pend_pc_d    = pend_pc;
    pend_valid_d = pend_valid;
    kill_d       = kill;
    buf_ir_d     = buf_ir;
    buf_pc_d     = buf_pc;
    pc_F_d       = pc_F;
    IR_F_d       = IR_F;
    valid_F_d    = valid_F;
    case (state)
      FETCH: begin
        if (complete && kill) begin
          // Wrong-path data: drop it and go fetch the saved target.
          kill_d       = 1'b0;
          fetch_pc_d   = pend_pc;
          pend_valid_d = 1'b0;
          if (!stop) valid_F_d = 1'b0;
        end else if (complete) begin
          if (redir_ok && slot_in_f) begin
            // Completing fetch is past the delay slot: discard it.
            fetch_pc_d   = redirect_pc;
            pend_valid_d = 1'b0;
            valid_F_d    = 1'b0;
          end else begin
            if (stop) begin
              buf_ir_d = im_rdata;
              buf_pc_d = fetch_pc;
              state_d  = HOLD;
            end else begin
              IR_F_d    = im_rdata;
              pc_F_d    = fetch_pc;
              valid_F_d = 1'b1;
            end
            if (redir_ok)        fetch_pc_d = redirect_pc;
            else if (pend_valid) fetch_pc_d = pend_pc;
            else                 fetch_pc_d = fetch_pc + 32'd4;
            pend_valid_d = 1'b0;
          end
        end else begin
          if (!stop) valid_F_d = 1'b0;
          if (redir_ok) begin
            pend_pc_d = redirect_pc;
            if (slot_in_f) kill_d = 1'b1;
            else           pend_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!stop) begin
          state_d = FETCH;
          if (redir_ok) begin
            // The buffered word follows the delay slot: drop it.
            fetch_pc_d = redirect_pc;
            valid_F_d  = 1'b0;
          end else begin
            IR_F_d    = buf_ir;
            pc_F_d    = buf_pc;
            valid_F_d = 1'b1;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH;
      fetch_pc   <= RESET_PC;
      pend_valid <= 1'b0;
      kill       <= 1'b0;
      pc_F       <= RESET_PC;
      IR_F       <= 32'd0;
      valid_F    <= 1'b0;
    end else begin
      state      <= state_d;
      fetch_pc   <= fetch_pc_d;
      pend_valid <= pend_valid_d;
      kill       <= kill_d;
      pc_F       <= pc_F_d;
      IR_F       <= IR_F_d;
      valid_F    <= valid_F_d;
    end
  end

  // Pending target and skid buffer contents are qualified by pend_valid,
  // kill and state, so they need no reset.
  always_ff @(posedge clk) begin
    pend_pc <= pend_pc_d;
    buf_ir  <= buf_ir_d;
    buf_pc  <= buf_pc_d;
  end

  a_no_stacked_redirect: assert property (@(posedge clk) disable iff (reset)
    !(redirect && (pend_valid || kill)));

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  logic        clk;
  logic        reset;
  logic        stop;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] pc_F;
  logic [31:0] pc4_F;
  logic [31:0] IR_F;
  logic        valid_F;

  int errors = 0;
  int checks = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stop(stop), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_req(im_req), .im_addr(im_addr),
    .im_ack(im_ack), .im_rdata(im_rdata), .pc_F(pc_F), .pc4_F(pc4_F),
    .IR_F(IR_F), .valid_F(valid_F)
  );

  // Memory contents: each word is its address XOR a tag.
  assign im_rdata = 32'hE000_0000 ^ im_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stop = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; im_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stop = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; im_ack = 1'b1;
    tick(); tick();
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL reset_im_req got=%b exp=0", im_req); end
    checks++; if (pc_F !== 32'h3000) begin errors++; $display("FAIL reset_pc_F got=%h exp=00003000", pc_F); end
    checks++; if (IR_F !== 32'h0) begin errors++; $display("FAIL reset_IR_F got=%h exp=00000000", IR_F); end
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL reset_valid_F got=%b exp=0", valid_F); end
    reset = 1'b0; im_ack = 1'b0;
    #1;
    checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL reset_release_req got=%b exp=1", im_req); end
    checks++; if (im_addr !== 32'h3000) begin errors++; $display("FAIL reset_release_addr got=%h exp=00003000", im_addr); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    im_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (valid_F !== 1'b1) begin errors++; $display("FAIL zw_valid[%0d] got=%b exp=1", i, valid_F); end
      checks++; if (pc_F !== 32'h3000 + 32'(4*i)) begin errors++; $display("FAIL zw_pc_F[%0d] got=%h exp=%h", i, pc_F, 32'h3000 + 32'(4*i)); end
      checks++; if (pc4_F !== 32'h3004 + 32'(4*i)) begin errors++; $display("FAIL zw_pc4_F[%0d] got=%h exp=%h", i, pc4_F, 32'h3004 + 32'(4*i)); end
      checks++; if (IR_F !== (32'hE000_0000 ^ (32'h3000 + 32'(4*i)))) begin errors++; $display("FAIL zw_IR_F[%0d] got=%h exp=%h", i, IR_F, 32'hE000_0000 ^ (32'h3000 + 32'(4*i))); end
      checks++; if (im_addr !== 32'h3004 + 32'(4*i)) begin errors++; $display("FAIL zw_im_addr[%0d] got=%h exp=%h", i, im_addr, 32'h3004 + 32'(4*i)); end
    end
  endtask

  task automatic test_latency();
    logic       exp_v [4];
    logic [31:0] exp_a [4];
    exp_v = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_a = '{32'h3000, 32'h3004, 32'h3004, 32'h3008};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      im_ack = exp_v[i];
      tick();
      checks++; if (valid_F !== exp_v[i]) begin errors++; $display("FAIL lat_valid[%0d] got=%b exp=%b", i, valid_F, exp_v[i]); end
      checks++; if (im_addr !== exp_a[i]) begin errors++; $display("FAIL lat_im_addr[%0d] got=%h exp=%h", i, im_addr, exp_a[i]); end
    end
    checks++; if (pc_F !== 32'h3004) begin errors++; $display("FAIL lat_pc_F got=%h exp=00003004", pc_F); end
  endtask

  task automatic test_stall();
    do_reset();
    im_ack = 1'b1;
    tick(); tick();
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc_F !== 32'h3004) begin errors++; $display("FAIL stall_pc_F[%0d] got=%h exp=00003004", i, pc_F); end
      checks++; if (valid_F !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, valid_F); end
      checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL stall_im_req[%0d] got=%b exp=0", i, im_req); end
    end
    stop = 1'b0; im_ack = 1'b0;
    tick();
    checks++; if (pc_F !== 32'h3008) begin errors++; $display("FAIL stall_release_pc got=%h exp=00003008", pc_F); end
    checks++; if (IR_F !== 32'hE000_3008) begin errors++; $display("FAIL stall_release_IR got=%h exp=e0003008", IR_F); end
    checks++; if (valid_F !== 1'b1) begin errors++; $display("FAIL stall_release_valid got=%b exp=1", valid_F); end
    checks++; if (im_req !== 1'b1) begin errors++; $display("FAIL stall_release_req got=%b exp=1", im_req); end
    checks++; if (im_addr !== 32'h300C) begin errors++; $display("FAIL stall_release_addr got=%h exp=0000300c", im_addr); end
  endtask

  task automatic test_redirect_kill();
    do_reset();
    im_ack = 1'b1;
    tick(); tick(); tick();
    checks++; if (pc_F !== 32'h3008) begin errors++; $display("FAIL kill_slot_pc got=%h exp=00003008", pc_F); end
    im_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect = 1'b0;
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL kill_bubble1 got=%b exp=0", valid_F); end
    checks++; if (im_addr !== 32'h300C) begin errors++; $display("FAIL kill_addr_hold got=%h exp=0000300c", im_addr); end
    im_ack = 1'b1;
    tick();
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL kill_dropped got=%b exp=0", valid_F); end
    checks++; if (im_addr !== 32'h3100) begin errors++; $display("FAIL kill_target_addr got=%h exp=00003100", im_addr); end
    tick();
    checks++; if (pc_F !== 32'h3100) begin errors++; $display("FAIL kill_target_pc got=%h exp=00003100", pc_F); end
    checks++; if (IR_F !== 32'hE000_3100) begin errors++; $display("FAIL kill_target_IR got=%h exp=e0003100", IR_F); end
    checks++; if (valid_F !== 1'b1) begin errors++; $display("FAIL kill_target_valid got=%b exp=1", valid_F); end
  endtask

  task automatic test_redirect_discard();
    do_reset();
    im_ack = 1'b1;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect = 1'b0;
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL disc_valid got=%b exp=0", valid_F); end
    checks++; if (im_addr !== 32'h3100) begin errors++; $display("FAIL disc_addr got=%h exp=00003100", im_addr); end
    tick();
    checks++; if (pc_F !== 32'h3100) begin errors++; $display("FAIL disc_pc got=%h exp=00003100", pc_F); end
  endtask

  task automatic test_redirect_slot();
    do_reset();
    im_ack = 1'b1;
    tick(); tick();
    im_ack = 1'b0;
    tick();
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL slot_bubble got=%b exp=0", valid_F); end
    redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect = 1'b0; im_ack = 1'b1;
    tick();
    checks++; if (pc_F !== 32'h3008) begin errors++; $display("FAIL slot_pc got=%h exp=00003008", pc_F); end
    checks++; if (valid_F !== 1'b1) begin errors++; $display("FAIL slot_valid got=%b exp=1", valid_F); end
    checks++; if (im_addr !== 32'h3100) begin errors++; $display("FAIL slot_next_addr got=%h exp=00003100", im_addr); end
    tick();
    checks++; if (pc_F !== 32'h3100) begin errors++; $display("FAIL slot_target_pc got=%h exp=00003100", pc_F); end
  endtask

  task automatic test_slot_same_cycle_wrap();
    do_reset();
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    tick();
    im_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    checks++; if (pc_F !== 32'h3004) begin errors++; $display("FAIL same_pc got=%h exp=00003004", pc_F); end
    checks++; if (valid_F !== 1'b1) begin errors++; $display("FAIL same_valid got=%b exp=1", valid_F); end
    checks++; if (im_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL same_addr got=%h exp=fffffffc", im_addr); end
    tick();
    checks++; if (pc_F !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc got=%h exp=fffffffc", pc_F); end
    checks++; if (pc4_F !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=00000000", pc4_F); end
    checks++; if (IR_F !== 32'h1FFF_FFFC) begin errors++; $display("FAIL wrap_IR got=%h exp=1ffffffc", IR_F); end
    checks++; if (im_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=00000000", im_addr); end
  endtask

  task automatic test_reset_mid_request();
    do_reset();
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    tick();
    checks++; if (im_addr !== 32'h3004) begin errors++; $display("FAIL mid_outstanding got=%h exp=00003004", im_addr); end
    reset = 1'b1;
    tick();
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL mid_req_in_reset got=%b exp=0", im_req); end
    im_ack = 1'b1;
    tick();
    checks++; if (im_req !== 1'b0) begin errors++; $display("FAIL mid_req_late_ack got=%b exp=0", im_req); end
    reset = 1'b0; im_ack = 1'b0;
    #1;
    checks++; if (im_addr !== 32'h3000) begin errors++; $display("FAIL mid_first_addr got=%h exp=00003000", im_addr); end
    checks++; if (IR_F !== 32'h0) begin errors++; $display("FAIL mid_IR got=%h exp=00000000", IR_F); end
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", valid_F); end
    tick();
    checks++; if (valid_F !== 1'b0) begin errors++; $display("FAIL mid_no_ghost got=%b exp=0", valid_F); end
    im_ack = 1'b1;
    tick();
    checks++; if (pc_F !== 32'h3000) begin errors++; $display("FAIL mid_first_pc got=%h exp=00003000", pc_F); end
    checks++; if (IR_F !== 32'hE000_3000) begin errors++; $display("FAIL mid_first_IR got=%h exp=e0003000", IR_F); end
  endtask

  initial begin
    reset = 1'b1; stop = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; im_ack = 1'b0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect_kill();
    test_redirect_discard();
    test_redirect_slot();
    test_slot_same_cycle_wrap();
    test_reset_mid_request();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
